instr_fetch_unit: RTL

Fetch stage directly upstream of the instruction decoder in the RISC-V lab CPU. It owns the PC, issues reads to a synchronous instruction memory with 1-cycle latency, and buffers returned words in a small FIFO. It presents {pc, instr} to the decoder over a valid/ready handshake and supports a branch/jump redirect that flushes all wrong-path work.

---
 rtl/instr_fetch_unit.sv | 122 ++++++++++++
 1 files changed

// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: owns the PC, issues single-cycle-latency reads to
// instruction memory, buffers returned words in a small FIFO and hands
// {pc, instr} to the decoder over valid/ready. A redirect flushes all
// wrong-path work and restarts fetch at the target.
module instr_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 2
) (
    input  logic        clk_i,
    input  logic        rst_i,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic [31:0] imem_rdata_i,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    output logic        instr_valid_o,
    input  logic        instr_ready_i,
    output logic [31:0] instr_o,
    output logic [31:0] pc_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [CW:0]   DEPTH_W = (CW+1)'(DEPTH);

    logic [31:0]   pc_q, pc_d;
    logic [31:0]   resp_pc_q, resp_pc_d;
    logic          inflight_q, inflight_d;
    logic          kill_q, kill_d;
    logic [AW-1:0] rptr_q, rptr_d;
    logic [AW-1:0] wptr_q, wptr_d;
    logic [CW-1:0] count_q, count_d;

    logic [31:0]   mem_pc  [DEPTH];
    logic [31:0]   mem_ins [DEPTH];

    logic          nonempty;
    logic          pop;
    logic          issue;
    logic          resp_ok;
    logic          fifo_we;
    logic [CW:0]   credit;

    // Handshake and credit: occupancy after this cycle's pop, counting the
    // word already in flight, must leave room for one more response.
    always_comb begin
        nonempty = (count_q != '0);
        credit   = {1'b0, count_q} + (CW+1)'(inflight_q) - (CW+1)'(pop);
        issue    = rst_i & ~redirect_i & (credit < DEPTH_W);
        resp_ok  = inflight_q & ~kill_q;
        fifo_we  = resp_ok & ~redirect_i;
    end

    assign instr_valid_o = rst_i & nonempty & ~redirect_i;
    assign pop           = instr_valid_o & instr_ready_i;
    assign imem_req_o    = issue;
    // While reset is held the address already shows the reset vector.
    assign imem_addr_o   = rst_i ? pc_q : RESET_PC;
    assign instr_o       = (rst_i & nonempty) ? mem_ins[rptr_q] : 32'h0;
    assign pc_o          = (rst_i & nonempty) ? mem_pc[rptr_q]  : 32'h0;

    // Next-state: redirect flushes everything; otherwise issue/push/pop.
    always_comb begin
        pc_d       = pc_q;
        resp_pc_d  = resp_pc_q;
        inflight_d = issue;
        kill_d     = redirect_i;
        rptr_d     = rptr_q;
        wptr_d     = wptr_q;
        count_d    = count_q;
        if (redirect_i) begin
            pc_d    = {redirect_pc_i[31:2], 2'b00};
            rptr_d  = '0;
            wptr_d  = '0;
            count_d = '0;
        end else begin
            if (issue) begin
                pc_d      = pc_q + 32'd4;
                resp_pc_d = pc_q;
            end
            if (fifo_we) wptr_d = wptr_q + AW'(1);
            if (pop)     rptr_d = rptr_q + AW'(1);
            count_d = count_q + CW'(fifo_we) - CW'(pop);
        end
    end

    // Control state register with synchronous active-low reset.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            pc_q       <= RESET_PC;
            resp_pc_q  <= 32'h0;
            inflight_q <= 1'b0;
            kill_q     <= 1'b0;
            rptr_q     <= '0;
            wptr_q     <= '0;
            count_q    <= '0;
        end else begin
            pc_q       <= pc_d;
            resp_pc_q  <= resp_pc_d;
            inflight_q <= inflight_d;
            kill_q     <= kill_d;
            rptr_q     <= rptr_d;
            wptr_q     <= wptr_d;
            count_q    <= count_d;
        end
    end

    // FIFO storage; contents are qualified by count so they need no reset.
    always_ff @(posedge clk_i) begin
        if (rst_i && fifo_we) begin
            mem_pc[wptr_q]  <= resp_pc_q;
            mem_ins[wptr_q] <= imem_rdata_i;
        end
    end

    a_no_push_full: assert property (@(posedge clk_i) disable iff (!rst_i)
        !(fifo_we && count_q == DEPTH_C));
    a_no_pop_empty: assert property (@(posedge clk_i) disable iff (!rst_i)
        !(pop && count_q == '0));

endmodule
